// File: rtl/sipp_core.sv
// sipp_core: multi-cycle six-plus-instruction processor with req/ack
// instruction and data ports, parametrised register file and PC width.
module sipp_core #(
  parameter int DW   = 16,
  parameter int NREG = 16,
  parameter int PW   = 8,
  parameter int AW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  output logic          i_req,
  output logic [PW-1:0] i_addr,
  input  logic          i_ack,
  input  logic [15:0]   i_data,
  output logic          d_req,
  output logic          d_we,
  output logic [AW-1:0] d_addr,
  output logic [DW-1:0] d_wdata,
  input  logic          d_ack,
  input  logic [DW-1:0] d_rdata,
  output logic          retire,
  output logic          halted,
  output logic          illegal
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'd0,
    OP_STORE = 4'd1,
    OP_ADD   = 4'd2,
    OP_LDI   = 4'd3,
    OP_SUB   = 4'd4,
    OP_JMPZ  = 4'd5,
    OP_AND   = 4'd6,
    OP_OR    = 4'd7,
    OP_HALT  = 4'd8
  } op_t;

  state_t          state, state_nx;
  logic [PW-1:0]   pc, pc_nx;
  logic [15:0]     ir;
  logic [DW-1:0]   regs [NREG];
  logic [DW-1:0]   op_a, op_b, op_c;
  logic            halted_q, illegal_q;
  logic            set_halt, set_illegal;
  logic            wb_en;
  logic [DW-1:0]   wb_data;

  op_t             opc;
  logic [RW-1:0]   ra, rb, rc;
  logic [DW-1:0]   imm_dw;
  logic [PW-1:0]   imm_pw;
  logic [PW-1:0]   pc_inc;

  assign opc    = op_t'(ir[15:12]);
  assign ra     = ir[8 +: RW];
  assign rb     = ir[4 +: RW];
  assign rc     = ir[0 +: RW];
  assign imm_dw = DW'($signed(ir[7:0]));
  assign imm_pw = PW'($signed(ir[7:0]));
  assign pc_inc = pc + PW'(1);

  assign i_addr  = pc;
  assign halted  = halted_q;
  assign illegal = illegal_q;

  // Next-state, handshake outputs, write-back selection and PC update.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    i_req       = 1'b0;
    d_req       = 1'b0;
    d_we        = 1'b0;
    d_addr      = '0;
    d_wdata     = '0;
    retire      = 1'b0;
    wb_en       = 1'b0;
    wb_data     = '0;
    set_halt    = 1'b0;
    set_illegal = 1'b0;
    case (state)
      S_RST:    state_nx = S_FETCH;
      S_FETCH: begin
        i_req = 1'b1;
        if (i_ack) state_nx = S_DECODE;
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        state_nx = S_FETCH;
        pc_nx    = pc_inc;
        retire   = 1'b1;
        case (opc)
          OP_ADD:  begin wb_en = 1'b1; wb_data = op_b + op_c; end
          OP_SUB:  begin wb_en = 1'b1; wb_data = op_b - op_c; end
          OP_AND:  begin wb_en = 1'b1; wb_data = op_b & op_c; end
          OP_OR:   begin wb_en = 1'b1; wb_data = op_b | op_c; end
          OP_LDI:  begin wb_en = 1'b1; wb_data = imm_dw; end
          OP_JMPZ: if (op_a == '0) pc_nx = pc + imm_pw;
          OP_LOAD, OP_STORE: begin
            state_nx = S_MEM;
            pc_nx    = pc;
            retire   = 1'b0;
          end
          OP_HALT: begin
            state_nx = S_HALT;
            pc_nx    = pc;
            retire   = 1'b0;
            set_halt = 1'b1;
          end
          default: set_illegal = 1'b1;
        endcase
      end
      S_MEM: begin
        d_req   = 1'b1;
        d_we    = (opc == OP_STORE);
        d_addr  = AW'(ir[7:0]);
        d_wdata = op_a;
        if (d_ack) begin
          wb_en    = (opc == OP_LOAD);
          wb_data  = d_rdata;
          pc_nx    = pc_inc;
          retire   = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_RST;
    endcase
  end

  // Control state, PC, instruction register, operand latches and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_RST;
      pc        <= '0;
      ir        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_c      <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (state == S_FETCH && i_ack) ir <= i_data;
      // Operands are captured before write-back, so ra==rb==rc uses old values.
      if (state == S_DECODE) begin
        op_a <= regs[ra];
        op_b <= regs[rb];
        op_c <= regs[rc];
      end
      if (set_halt)    halted_q  <= 1'b1;
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  // Register file write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[ra] <= wb_data;
    end
  end

endmodule

// File: tb/tb_sipp_core.sv
// Self-checking bench for sipp_core: directed scenarios plus random programs
// checked against an instruction-level reference model.
module tb_sipp_core;

  localparam int DW   = 16;
  localparam int NREG = 16;
  localparam int PW   = 8;
  localparam int AW   = 8;
  localparam logic [15:0] HALT_W = 16'h8000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req, i_ack;
  logic [PW-1:0] i_addr;
  logic [15:0]   i_data;
  logic          d_req, d_we, d_ack;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          retire, halted, illegal;

  always #5 clk = ~clk;

  sipp_core #(.DW(DW), .NREG(NREG), .PW(PW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .retire(retire), .halted(halted), .illegal(illegal)
  );

  logic [15:0]   imem [256];
  logic [DW-1:0] dmem [256];
  int            i_lat = 0;
  int            d_lat = 0;
  logic          late_dack = 1'b0;
  int            cyc;
  int            fetch_q[$];
  int            st_addr_q[$];
  int            st_data_q[$];
  int            retire_cyc_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  // Memory responders with programmable latency (-1 = random 0..3) and a retire log.
  initial begin
    int icnt, dcnt, iwant, dwant;
    icnt = 0; dcnt = 0; iwant = 0; dwant = 0;
    i_ack = 1'b0; i_data = '0; d_ack = 1'b0; d_rdata = '0;
    forever begin
      @(negedge clk);
      i_ack = 1'b0; i_data = '0; d_ack = late_dack; d_rdata = '0;
      if (!rst) begin
        icnt = 0; dcnt = 0;
      end else begin
        if (i_req) begin
          if (icnt == 0) iwant = (i_lat < 0) ? int'($urandom_range(3, 0)) : i_lat;
          if (icnt >= iwant) begin
            i_ack = 1'b1; i_data = imem[i_addr];
            fetch_q.push_back(int'(i_addr)); icnt = 0;
          end else icnt++;
        end else icnt = 0;
        if (d_req) begin
          if (dcnt == 0) dwant = (d_lat < 0) ? int'($urandom_range(3, 0)) : d_lat;
          if (dcnt >= dwant) begin
            d_ack = 1'b1;
            if (d_we) begin
              dmem[d_addr] = d_wdata;
              st_addr_q.push_back(int'(d_addr));
              st_data_q.push_back(int'(d_wdata));
            end else d_rdata = dmem[d_addr];
            dcnt = 0;
          end else dcnt++;
        end else dcnt = 0;
      end
      #1;
      if (rst && retire) retire_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] enc(input int op, input int ra, input int rb, input int rc);
    return {op[3:0], ra[3:0], rb[3:0], rc[3:0]};
  endfunction

  function automatic logic [15:0] enc_i(input int op, input int ra, input int imm);
    return {op[3:0], ra[3:0], imm[7:0]};
  endfunction

  task automatic clear_mem();
    for (int k = 0; k < 256; k++) begin
      imem[k] = HALT_W;
      dmem[k] = DW'($urandom);
    end
  endtask

  task automatic start_prog();
    rst = 1'b0;
    fetch_q.delete(); st_addr_q.delete(); st_data_q.delete(); retire_cyc_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_halt(input int budget, output bit done);
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #2;
      if (halted) begin done = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk); #3;
    n_checks++; if (i_req !== 1'b0) begin n_fail++; $display("FAIL reset_i_req: got %b want 0", i_req); end
    n_checks++; if (d_req !== 1'b0) begin n_fail++; $display("FAIL reset_d_req: got %b want 0", d_req); end
    n_checks++; if (i_addr !== '0) begin n_fail++; $display("FAIL reset_i_addr: got %h want 0", i_addr); end
    n_checks++; if ({retire, halted, illegal} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {retire, halted, illegal}); end
  endtask

  task automatic test_alu_timing();
    bit done;
    clear_mem(); i_lat = 0; d_lat = 0;
    imem[0] = enc_i(3, 1, 5);
    imem[1] = enc_i(3, 2, 8'hFD);
    imem[2] = enc(2, 3, 1, 2);
    imem[3] = enc_i(1, 3, 8'h80);
    start_prog(); wait_halt(200, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL alu_halt_timeout: halted=%b want 1", halted); end
    n_checks++; if (retire_cyc_q.size() < 3) begin
      n_fail++; $display("FAIL alu_retire_count: got %0d want >=3", retire_cyc_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++; if (retire_cyc_q[k] != 3 * (k + 1)) begin
          n_fail++; $display("FAIL alu_retire_cycle[%0d]: got %0d want %0d", k, retire_cyc_q[k], 3 * (k + 1)); end
        n_checks++; if (fetch_q[k] != k) begin
          n_fail++; $display("FAIL alu_fetch_addr[%0d]: got %0d want %0d", k, fetch_q[k], k); end
      end
    end
    n_checks++; if (dmem[8'h80] !== 16'd2) begin n_fail++; $display("FAIL alu_add_result: got %h want 0002", dmem[8'h80]); end
  endtask

  task automatic test_logic_ops();
    bit done;
    clear_mem(); i_lat = 1; d_lat = 0;
    imem[0] = enc_i(3, 1, 5);
    imem[1] = enc_i(3, 2, 8'hFD);
    imem[2] = enc(4, 4, 2, 1);
    imem[3] = enc(7, 5, 1, 2);
    imem[4] = enc(6, 6, 1, 2);
    imem[5] = enc(2, 1, 1, 1);
    imem[6] = enc_i(1, 4, 8'h81);
    imem[7] = enc_i(1, 5, 8'h82);
    imem[8] = enc_i(1, 6, 8'h83);
    imem[9] = enc_i(1, 1, 8'h84);
    start_prog(); wait_halt(300, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL logic_halt_timeout: halted=%b want 1", halted); end
    n_checks++; if (dmem[8'h81] !== 16'hFFF8) begin n_fail++; $display("FAIL sub_result: got %h want fff8", dmem[8'h81]); end
    n_checks++; if (dmem[8'h82] !== 16'hFFFD) begin n_fail++; $display("FAIL or_result: got %h want fffd", dmem[8'h82]); end
    n_checks++; if (dmem[8'h83] !== 16'h0005) begin n_fail++; $display("FAIL and_result: got %h want 0005", dmem[8'h83]); end
    n_checks++; if (dmem[8'h84] !== 16'h000A) begin n_fail++; $display("FAIL self_add_result: got %h want 000a", dmem[8'h84]); end
    i_lat = 0;
  endtask

  task automatic test_mem_latency();
    bit done;
    int held, bad;
    clear_mem(); i_lat = 0; d_lat = 3;
    dmem[8'h20] = '0;
    imem[0] = enc_i(3, 1, 5);
    imem[1] = enc_i(1, 1, 8'h20);
    imem[2] = enc_i(0, 5, 8'h20);
    imem[3] = enc_i(1, 5, 8'h81);
    start_prog();
    for (int k = 0; k < 50; k++) begin @(negedge clk); #2; if (d_req) break; end
    held = 0; bad = 0;
    while (d_req && held < 20) begin
      held++;
      if (d_we !== 1'b1 || d_addr !== 8'h20 || d_wdata !== 16'd5) bad++;
      @(negedge clk); #2;
    end
    n_checks++; if (held != 4) begin n_fail++; $display("FAIL store_hold_cycles: got %0d want 4", held); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL store_stable: got %0d unstable cycles want 0", bad); end
    wait_halt(300, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL mem_halt_timeout: halted=%b want 1", halted); end
    n_checks++; if (retire_cyc_q.size() < 2 || retire_cyc_q[1] != 10) begin
      n_fail++; $display("FAIL store_retire_cycle: got %0d want 10", retire_cyc_q.size() < 2 ? -1 : retire_cyc_q[1]); end
    n_checks++; if (dmem[8'h20] !== 16'd5) begin n_fail++; $display("FAIL store_data: got %h want 0005", dmem[8'h20]); end
    n_checks++; if (dmem[8'h81] !== 16'd5) begin n_fail++; $display("FAIL load_data: got %h want 0005", dmem[8'h81]); end
    d_lat = 0;
  endtask

  task automatic test_branch();
    bit done;
    int exp_f [5];
    exp_f = '{0, 8'hFE, 1, 2, 3};
    clear_mem(); i_lat = 0; d_lat = 0;
    imem[0]     = enc_i(5, 0, 8'hFE);
    imem[8'hFE] = enc_i(5, 0, 3);
    imem[1]     = enc_i(3, 1, 7);
    imem[2]     = enc_i(5, 1, 4);
    start_prog(); wait_halt(200, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL branch_halt_timeout: halted=%b want 1", halted); end
    n_checks++; if (fetch_q.size() != 5) begin
      n_fail++; $display("FAIL branch_fetch_count: got %0d want 5", fetch_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++; if (fetch_q[k] != exp_f[k]) begin
          n_fail++; $display("FAIL branch_fetch[%0d]: got %h want %h", k, fetch_q[k], exp_f[k]); end
      end
    end
  endtask

  task automatic test_illegal_halt();
    bit done;
    int bad_req, n_ret;
    clear_mem(); i_lat = 0; d_lat = 0;
    imem[0] = 16'hC000;
    imem[1] = HALT_W;
    start_prog(); wait_halt(200, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL halt_timeout: halted=%b want 1", halted); end
    n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got %b want 1", illegal); end
    n_checks++; if (fetch_q.size() != 2) begin n_fail++; $display("FAIL halt_fetch_count: got %0d want 2", fetch_q.size()); end
    bad_req = 0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); #2; if (i_req) bad_req++; end
    n_ret = retire_cyc_q.size();
    n_checks++; if (n_ret != 1) begin n_fail++; $display("FAIL halt_retire_count: got %0d want 1", n_ret); end
    n_checks++; if (bad_req != 0) begin n_fail++; $display("FAIL halt_i_req: got %0d cycles high want 0", bad_req); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halted_sticky: got %b want 1", halted); end
  endtask

  task automatic test_reset_mid();
    bit done;
    clear_mem(); i_lat = 0; d_lat = 100;
    dmem[8'h30] = 16'h1234;
    imem[0] = enc_i(3, 1, 9);
    imem[1] = enc_i(1, 1, 8'h30);
    start_prog();
    for (int k = 0; k < 50; k++) begin @(negedge clk); #2; if (d_req) break; end
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    n_checks++; if (d_req !== 1'b0) begin n_fail++; $display("FAIL midreset_d_req: got %b want 0", d_req); end
    n_checks++; if (i_req !== 1'b0) begin n_fail++; $display("FAIL midreset_i_req: got %b want 0", i_req); end
    d_lat = 0;
    for (int k = 0; k < NREG; k++) begin
      imem[k] = enc_i(1, k, 8'hF0 + k);
      dmem[8'hF0 + k] = 16'hA5A5;
    end
    imem[NREG] = HALT_W;
    fetch_q.delete(); st_addr_q.delete(); st_data_q.delete(); retire_cyc_q.delete();
    @(negedge clk); #4 late_dack = 1'b1;
    @(negedge clk); rst = 1'b1;
    #1;
    n_checks++; if (i_addr !== '0) begin n_fail++; $display("FAIL midreset_i_addr: got %h want 00", i_addr); end
    repeat (2) @(negedge clk);
    #4 late_dack = 1'b0;
    wait_halt(400, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL midreset_halt_timeout: halted=%b want 1", halted); end
    n_checks++; if (dmem[8'h30] !== 16'h1234) begin n_fail++; $display("FAIL midreset_no_store: got %h want 1234", dmem[8'h30]); end
    n_checks++; if (fetch_q.size() < 1 || fetch_q[0] != 0) begin
      n_fail++; $display("FAIL midreset_first_fetch: got %0d want 0", fetch_q.size() < 1 ? -1 : fetch_q[0]); end
    n_checks++; if (st_addr_q.size() != NREG) begin n_fail++; $display("FAIL midreset_store_count: got %0d want %0d", st_addr_q.size(), NREG); end
    for (int k = 0; k < NREG; k++) begin
      n_checks++; if (dmem[8'hF0 + k] !== '0) begin
        n_fail++; $display("FAIL midreset_reg[%0d]: got %h want 0000", k, dmem[8'hF0 + k]); end
    end
  endtask

  task automatic test_random();
    bit done;
    for (int it = 0; it < 4; it++) begin
      longint mregs [NREG];
      logic [DW-1:0] mdmem [256];
      int exp_fetch[$], exp_sa[$], exp_sd[$];
      int pc, exp_ret, steps, nmin;
      bit exp_ill, exp_halt;
      longint mask;
      clear_mem(); i_lat = -1; d_lat = -1;
      for (int k = 0; k < 40; k++) begin
        int r, op;
        r = int'($urandom_range(9, 0));
        op = (r == 8) ? 9 + int'($urandom_range(6, 0)) : (r == 9 ? 3 : r);
        if (op == 5) imem[k] = enc_i(5, $urandom_range(15, 0), $urandom_range(4, 1));
        else if (op == 0 || op == 1) imem[k] = enc_i(op, $urandom_range(15, 0), $urandom_range(127, 0));
        else imem[k] = {op[3:0], 12'($urandom)};
      end
      for (int k = 0; k < NREG; k++) imem[40 + k] = enc_i(1, k, 8'hF0 + k);
      for (int k = 0; k < 256; k++) mdmem[k] = dmem[k];
      // Instruction-level reference execution.
      mask = (longint'(1) << DW) - 1;
      for (int k = 0; k < NREG; k++) mregs[k] = 0;
      pc = 0; exp_ret = 0; exp_ill = 0; exp_halt = 0; steps = 0;
      while (!exp_halt && steps < 500) begin
        logic [15:0] ins;
        int a, b, c, imm, s;
        ins = imem[pc];
        exp_fetch.push_back(pc);
        a = int'(ins[11:8]) % NREG; b = int'(ins[7:4]) % NREG; c = int'(ins[3:0]) % NREG;
        imm = int'(ins[7:0]); s = ins[7] ? imm - 256 : imm;
        steps++;
        case (int'(ins[15:12]))
          0: mregs[a] = longint'(mdmem[imm]);
          1: begin exp_sa.push_back(imm); exp_sd.push_back(int'(mregs[a])); mdmem[imm] = DW'(mregs[a]); end
          2: mregs[a] = (mregs[b] + mregs[c]) & mask;
          3: mregs[a] = longint'(s) & mask;
          4: mregs[a] = (mregs[b] - mregs[c]) & mask;
          6: mregs[a] = mregs[b] & mregs[c];
          7: mregs[a] = mregs[b] | mregs[c];
          8: exp_halt = 1;
          5: ;
          default: exp_ill = 1;
        endcase
        if (!exp_halt) begin
          exp_ret++;
          if (int'(ins[15:12]) == 5 && mregs[a] == 0) pc = (pc + s) & ((1 << PW) - 1);
          else pc = (pc + 1) & ((1 << PW) - 1);
        end
      end
      start_prog(); wait_halt(5000, done);
      n_checks++; if (!done) begin n_fail++; $display("FAIL rand%0d_halt_timeout: halted=%b want 1", it, halted); end
      n_checks++; if (retire_cyc_q.size() != exp_ret) begin
        n_fail++; $display("FAIL rand%0d_retire_count: got %0d want %0d", it, retire_cyc_q.size(), exp_ret); end
      n_checks++; if (illegal !== exp_ill) begin
        n_fail++; $display("FAIL rand%0d_illegal: got %b want %b", it, illegal, exp_ill); end
      n_checks++; if (fetch_q.size() != exp_fetch.size()) begin
        n_fail++; $display("FAIL rand%0d_fetch_count: got %0d want %0d", it, fetch_q.size(), exp_fetch.size()); end
      nmin = (fetch_q.size() < exp_fetch.size()) ? fetch_q.size() : exp_fetch.size();
      for (int k = 0; k < nmin; k++) begin
        n_checks++; if (fetch_q[k] != exp_fetch[k]) begin
          n_fail++; $display("FAIL rand%0d_fetch[%0d]: got %h want %h", it, k, fetch_q[k], exp_fetch[k]); end
      end
      n_checks++; if (st_addr_q.size() != exp_sa.size()) begin
        n_fail++; $display("FAIL rand%0d_store_count: got %0d want %0d", it, st_addr_q.size(), exp_sa.size()); end
      nmin = (st_addr_q.size() < exp_sa.size()) ? st_addr_q.size() : exp_sa.size();
      for (int k = 0; k < nmin; k++) begin
        n_checks++; if (st_addr_q[k] != exp_sa[k] || st_data_q[k] != exp_sd[k]) begin
          n_fail++; $display("FAIL rand%0d_store[%0d]: got %h<=%h want %h<=%h", it, k,
                             st_addr_q[k], st_data_q[k], exp_sa[k], exp_sd[k]); end
      end
    end
    i_lat = 0; d_lat = 0;
  endtask

  initial begin
    test_reset();
    test_alu_timing();
    test_logic_ops();
    test_mem_latency();
    test_branch();
    test_illegal_halt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipp_core.md
Name: sipp_core

Overview:
- Parametrised single-module successor to the six-instruction programmable processor.
- Runs a multi-cycle fetch/decode/execute FSM with an external instruction port and an external data-memory port. Both ports use a req/ack handshake with variable latency.
- Register file depth, data width and PC width are generic.
- Adds over the previous generation: subtract, AND/OR, load-immediate, relative branch, halt, illegal-opcode flag and a retire strobe.

Parameters:
- DW, 16, data and register width (8..32).
- NREG, 16, number of registers (power of two, 2..16). A register index is the low log2(NREG) bits of a 4-bit field; the upper bits are ignored.
- PW, 8, program counter and instruction address width.
- AW, 8, data address width (fixed to 8 by the imm8 field; tied to 8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset. All state clears while low.
- i_req  out  1  instruction fetch request.
- i_addr  out  PW  fetch address, equal to the PC.
- i_ack  in  1  fetch complete; i_data is valid this cycle.
- i_data  in  16  instruction word.
- d_req  out  1  data access request.
- d_we  out  1  1 = store, 0 = load.
- d_addr  out  AW  data address.
- d_wdata  out  DW  store data.
- d_ack  in  1  access complete; d_rdata is valid this cycle if it is a load.
- d_rdata  in  DW  load data.
- retire  out  1  one-cycle pulse when an instruction commits.
- halted  out  1  high once HALT has executed; sticky until reset.
- illegal  out  1  sticky; set when an undefined opcode executes.

Behaviour:
- Instruction format: op[15:12], ra[11:8], rb[7:4], rc[3:0]; imm8 = [7:0].
- Opcodes:
  - 0 LOAD: ra <= mem[imm8].
  - 1 STORE: mem[imm8] <= ra.
  - 2 ADD: ra <= rb + rc.
  - 3 LDI: ra <= sext(imm8).
  - 4 SUB: ra <= rb - rc.
  - 5 JMPZ: if ra == 0 then pc <= pc + sext(imm8), else pc <= pc + 1.
  - 6 AND: ra <= rb & rc.
  - 7 OR: ra <= rb | rc.
  - 8 HALT.
  - 9..15: illegal. Executes as a NOP (pc + 1), sets illegal and pulses retire.
- Arithmetic is modulo 2^DW. The PC wraps modulo 2^PW, including on a backward or forward branch.
- Reset (rst low): state = RST. pc, IR and all registers = 0. All outputs = 0.
- FSM states and transitions:
  - RST -> FETCH on the first clock after rst is released.
  - FETCH: i_req = 1 and i_addr = pc, held stable until i_ack. On i_ack: IR <= i_data, go to DECODE. No i_req is raised in any other state.
  - DECODE: read the register operands -> EXEC.
  - EXEC:
    - ALU, LDI, JMPZ and illegal ops: write back, update pc, pulse retire, go to FETCH.
    - LOAD and STORE: go to MEM.
    - HALT: set halted, go to HALT. pc and retire do not advance.
  - MEM: d_req = 1, with d_we, d_addr and d_wdata held stable until d_ack. On d_ack: a load writes ra <= d_rdata; then pc + 1, pulse retire, go to FETCH.
  - HALT: terminal. Only reset leaves it.
- Latency with single-cycle ack:
  - ALU, LDI and JMPZ: 3 cycles from i_req to retire.
  - LOAD and STORE: 4 cycles.
  - Each cycle of ack delay adds one cycle.
- i_ack or d_ack arriving while the matching req is low is ignored.
- An instruction that reads and writes the same register (e.g. ADD r1, r1, r1) uses the old values for its operands.
- rst low mid-transaction: i_req and d_req drop asynchronously and no write-back occurs.
- Registers reset to 0 and have no special register 0.

Test Plan:
1. Reset, then LDI r1,5; LDI r2,-3; ADD r3,r1,r2 with immediate ack -> r3 = 2. retire pulses at cycles 3, 6 and 9 after release. i_addr steps 0, 1, 2.
2. SUB r4,r2,r1 (DW=16) -> r4 = 0xFFF8. Repeat with DW=8 -> r4 = 0xF8.
3. STORE r1 to 0x20 with d_ack delayed 3 cycles -> d_req, d_we=1, d_addr=0x20 and d_wdata=5 are held stable for 4 cycles. Then LOAD r5 from 0x20 returning 5 -> r5 = 5.
4. JMPZ r0,-2 at pc=0 with PW=8 -> next i_addr = 0xFE. JMPZ r1,+4 with r1 != 0 -> i_addr = pc + 1.
5. Opcode 0xC, then HALT -> illegal = 1 and retire pulses once for the illegal op. Then halted = 1, i_req stays 0 and no further retire.
6. Pull rst low while in MEM with d_ack pending -> d_req = 0 immediately. After release: i_addr = 0, all registers = 0, and a late d_ack is ignored.
